// File: rtl/dump_pkg.sv
// Shared types and default sizing for the data-memory dump engine.
// Imported by data_mem_dump.
package dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        PRES,
        FIN
    } state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STRIDE = 4;

endpackage

// File: rtl/data_mem_dump.sv
// Walks data memory after a START pulse and streams each word on a
// valid/ready port. Optional running checksum: DATA_MEM_DUMP_CSUM_EN.
module data_mem_dump
    import dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STRIDE = DEF_STRIDE
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W-1:0] WORD_CNT,
    output logic              MEM_RD_EN,
    output logic [ADDR_W-1:0] MEM_RD_ADDR,
    input  logic [DATA_W-1:0] MEM_RD_DATA,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    output logic [DATA_W-1:0] DUMP_DATA,
    output logic [ADDR_W-1:0] DUMP_ADDR,
    output logic              DUMP_LAST,
    output logic              BUSY,
    output logic              DONE
`ifdef DATA_MEM_DUMP_CSUM_EN
    ,
    output logic [DATA_W-1:0] DUMP_CSUM
`endif
);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] next_addr;
    logic              hs;

    assign next_addr = cur_addr + ADDR_W'(STRIDE);
    assign hs        = DUMP_VALID & DUMP_READY;

    // Dump sequencer: one read, one capture, then hold until accepted.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            MEM_RD_EN   <= 1'b0;
            MEM_RD_ADDR <= '0;
            DUMP_VALID  <= 1'b0;
            DUMP_DATA   <= '0;
            DUMP_ADDR   <= '0;
            DUMP_LAST   <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        cur_addr  <= BASE_ADDR;
                        remaining <= WORD_CNT;
                        BUSY      <= 1'b1;
                        if (WORD_CNT == '0) begin
                            state <= FIN;
                        end else begin
                            state       <= RD;
                            MEM_RD_EN   <= 1'b1;
                            MEM_RD_ADDR <= BASE_ADDR;
                        end
                    end
                end
                RD: begin
                    MEM_RD_EN <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    DUMP_DATA  <= MEM_RD_DATA;
                    DUMP_ADDR  <= cur_addr;
                    DUMP_LAST  <= (remaining == ADDR_W'(1));
                    DUMP_VALID <= 1'b1;
                    state      <= PRES;
                end
                PRES: begin
                    if (hs) begin
                        DUMP_VALID <= 1'b0;
                        DUMP_LAST  <= 1'b0;
                        cur_addr   <= next_addr;
                        remaining  <= remaining - ADDR_W'(1);
                        if (remaining == ADDR_W'(1)) begin
                            state <= FIN;
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                        end else begin
                            state       <= RD;
                            MEM_RD_EN   <= 1'b1;
                            MEM_RD_ADDR <= next_addr;
                        end
                    end
                end
                FIN: begin
                    // Empty dumps arrive with DONE low and spend one
                    // extra cycle here before pulsing it.
                    if (DONE) begin
                        DONE  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        DONE <= 1'b1;
                        BUSY <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_MEM_DUMP_CSUM_EN
    // Running sum of accepted words, restarted by each accepted START.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            DUMP_CSUM <= '0;
        end else if (state == IDLE && START) begin
            DUMP_CSUM <= '0;
        end else if (state == PRES && hs) begin
            DUMP_CSUM <= DUMP_CSUM + DUMP_DATA;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_dump.sv
// Directed bench for data_mem_dump: ordering, latency, stall, wrap,
// empty dump, ignored restart, async abort, optional checksum.
module tb_data_mem_dump;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          START = 1'b0;
    logic [AW-1:0] BASE_ADDR = '0;
    logic [AW-1:0] WORD_CNT = '0;
    logic          MEM_RD_EN;
    logic [AW-1:0] MEM_RD_ADDR;
    logic [DW-1:0] MEM_RD_DATA = '0;
    logic          DUMP_VALID;
    logic          DUMP_READY = 1'b1;
    logic [DW-1:0] DUMP_DATA;
    logic [AW-1:0] DUMP_ADDR;
    logic          DUMP_LAST;
    logic          BUSY;
    logic          DONE;
`ifdef DATA_MEM_DUMP_CSUM_EN
    logic [DW-1:0] DUMP_CSUM;
`endif

    int checks = 0;
    int errors = 0;

    data_mem_dump dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .START      (START),
        .BASE_ADDR  (BASE_ADDR),
        .WORD_CNT   (WORD_CNT),
        .MEM_RD_EN  (MEM_RD_EN),
        .MEM_RD_ADDR(MEM_RD_ADDR),
        .MEM_RD_DATA(MEM_RD_DATA),
        .DUMP_VALID (DUMP_VALID),
        .DUMP_READY (DUMP_READY),
        .DUMP_DATA  (DUMP_DATA),
        .DUMP_ADDR  (DUMP_ADDR),
        .DUMP_LAST  (DUMP_LAST),
        .BUSY       (BUSY),
        .DONE       (DONE)
`ifdef DATA_MEM_DUMP_CSUM_EN
        ,
        .DUMP_CSUM  (DUMP_CSUM)
`endif
    );

    always #5 CLK = ~CLK;

    // Synchronous-read memory model on the second port
    logic [DW-1:0] mem [0:1023];
    always @(posedge CLK) begin
        if (MEM_RD_EN) MEM_RD_DATA <= mem[MEM_RD_ADDR];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Observation log, sampled mid-cycle
    logic [DW-1:0] hs_data [$];
    logic [AW-1:0] hs_addr [$];
    logic          hs_last [$];
    int            hs_cyc  [$];
    int            vrise_q [$];
    int            done_q  [$];
    int            rd_cnt = 0;
    logic          prev_v = 1'b0;

    always @(negedge CLK) begin
        if (MEM_RD_EN) rd_cnt <= rd_cnt + 1;
        if (DUMP_VALID && !prev_v) vrise_q.push_back(cyc);
        prev_v <= DUMP_VALID;
        if (DUMP_VALID && DUMP_READY) begin
            hs_data.push_back(DUMP_DATA);
            hs_addr.push_back(DUMP_ADDR);
            hs_last.push_back(DUMP_LAST);
            hs_cyc.push_back(cyc);
        end
        if (DONE) done_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rden"}, 32'(MEM_RD_EN), 32'(0));
        chk({tag, "_rdad"}, 32'(MEM_RD_ADDR), 32'(0));
        chk({tag, "_vld"}, 32'(DUMP_VALID), 32'(0));
        chk({tag, "_data"}, DUMP_DATA, 32'(0));
        chk({tag, "_addr"}, 32'(DUMP_ADDR), 32'(0));
        chk({tag, "_last"}, 32'(DUMP_LAST), 32'(0));
        chk({tag, "_busy"}, 32'(BUSY), 32'(0));
        chk({tag, "_done"}, 32'(DONE), 32'(0));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_dump(input logic [AW-1:0] base,
                            input logic [AW-1:0] cnt,
                            input int stall_idx, input int stall_len);
        int hs0, rd0, dn0, vr0, sc, n, st, nw;
        logic [AW-1:0] a;
        hs0 = hs_data.size();
        rd0 = rd_cnt;
        dn0 = done_q.size();
        vr0 = vrise_q.size();
        BASE_ADDR = base;
        WORD_CNT = cnt;
        START = 1'b1;
        sc = cyc;
        tick();
        START = 1'b0;
        chk("busy_start", 32'(BUSY), 32'(1));
        n = 0;
        st = 0;
        while (done_q.size() == dn0 && n < 200) begin
            nw = hs_data.size() - hs0;
            if (DUMP_VALID && nw == stall_idx && st < stall_len) begin
                a = base + AW'(stall_idx * 4);
                chk("stall_vld", 32'(DUMP_VALID), 32'(1));
                chk("stall_data", DUMP_DATA, mem[a]);
                chk("stall_addr", 32'(DUMP_ADDR), 32'(a));
                chk("stall_last", 32'(DUMP_LAST),
                    32'(stall_idx == int'(cnt) - 1));
                DUMP_READY = 1'b0;
                st++;
            end else begin
                DUMP_READY = 1'b1;
            end
            tick();
            n++;
        end
        DUMP_READY = 1'b1;
        chk("timeout", 32'(n < 200), 32'(1));
        chk("words", 32'(hs_data.size() - hs0), 32'(cnt));
        chk("reads", 32'(rd_cnt - rd0), 32'(cnt));
        chk("valids", 32'(vrise_q.size() - vr0), 32'(cnt));
        chk("done_n", 32'(done_q.size() - dn0), 32'(1));
        if (cnt == '0) begin
            if (done_q.size() > dn0)
                chk("done_lat0", 32'(done_q[dn0] - sc), 32'(2));
        end else if (hs_data.size() - hs0 == int'(cnt) &&
                     done_q.size() > dn0) begin
            chk("first_v", 32'(vrise_q[vr0] - sc), 32'(3));
            chk("done_lat", 32'(done_q[dn0] - hs_cyc[$]), 32'(1));
            for (int i = 0; i < int'(cnt); i++) begin
                a = base + AW'(i * 4);
                chk("w_data", hs_data[hs0 + i], mem[a]);
                chk("w_addr", 32'(hs_addr[hs0 + i]), 32'(a));
                chk("w_last", 32'(hs_last[hs0 + i]),
                    32'(i == int'(cnt) - 1));
            end
        end
        chk("busy_end", 32'(BUSY), 32'(0));
        chk("done_end", 32'(DONE), 32'(0));
    endtask

    initial begin
        int rd0, dn0, n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A000000 + 32'(i);
        mem[0]     = 32'hDEADBEEF;
        mem[4]     = 32'h12345678;
        mem[8]     = 32'h00000001;
        mem[10'h3FC] = 32'hCAFEF00D;
        mem[10'h040] = 32'hFFFFFFFF;
        mem[10'h044] = 32'h00000002;

        #1;
        chk_zero("rst");
        repeat (3) tick();
        RSTn = 1'b1;
        tick();
        chk_zero("idle");

        // Basic three-word dump
        run_dump(10'h000, 10'd3, -1, 0);
        tick();

        // Second word held off for five cycles
        run_dump(10'h000, 10'd3, 1, 5);
        tick();

        // Empty dump
        run_dump(10'h000, 10'd0, -1, 0);
        tick();

        // Address wrap at top of memory
        run_dump(10'h3FC, 10'd2, -1, 0);
        tick();

`ifdef DATA_MEM_DUMP_CSUM_EN
        run_dump(10'h040, 10'd2, -1, 0);
        chk("csum", DUMP_CSUM, 32'h00000001);
        tick();
        chk("csum_hold", DUMP_CSUM, 32'h00000001);
`endif

        // Restart ignored while busy, then abort with reset
        BASE_ADDR = 10'h000;
        WORD_CNT = 10'd3;
        DUMP_READY = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (!DUMP_VALID && n < 10) begin
            tick();
            n++;
        end
        chk("re_wait", 32'(n < 10), 32'(1));
        rd0 = rd_cnt;
        BASE_ADDR = 10'h100;
        WORD_CNT = 10'd5;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("re_addr", 32'(DUMP_ADDR), 32'h0);
        chk("re_data", DUMP_DATA, 32'hDEADBEEF);
        chk("re_vld", 32'(DUMP_VALID), 32'(1));
        tick();
        chk("re_rd", 32'(rd_cnt - rd0), 32'(0));
        DUMP_READY = 1'b1;
        tick();
        tick();
        chk("ab_busy", 32'(BUSY), 32'(1));
        dn0 = done_q.size();
        #2;
        RSTn = 1'b0;
        #1;
        chk_zero("abort");
        repeat (3) tick();
        chk("ab_nodone", 32'(done_q.size() - dn0), 32'(0));
        RSTn = 1'b1;
        tick();
        chk_zero("rel");

        // Fresh dump after release
        run_dump(10'h000, 10'd3, -1, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_dump.md
Name: data_mem_dump

Overview:
- Read-back counterpart of the data-memory load port: after the core signals completion, walks data memory and streams each word out over a valid/ready interface.
- Serves bench result checking and a future host link.
- Sits beside the data memory on a second read port; does not touch the load path.

Parameters:
- ADDR_W, 10, memory address width (matches the load address width).
- DATA_W, 32, memory word width.
- STRIDE, 4, address increment between dumped words; matches the load layout of one data word followed by three zero-padding entries.

Ports:
- CLK  in  1  clock, rising-edge.
- RSTn  in  1  reset; asynchronous assert, active-low; release synchronous to CLK.
- START  in  1  one-cycle pulse; begins a dump, sampled only in IDLE.
- BASE_ADDR  in  ADDR_W  first address; captured on accepted START.
- WORD_CNT  in  ADDR_W  number of words to dump; captured on accepted START; 0 means no words.
- MEM_RD_EN  out  1  memory read strobe; data returns the next cycle.
- MEM_RD_ADDR  out  ADDR_W  memory read address.
- MEM_RD_DATA  in  DATA_W  read data, valid one cycle after MEM_RD_EN.
- DUMP_VALID  out  1  stream word valid.
- DUMP_READY  in  1  stream sink ready.
- DUMP_DATA  out  DATA_W  word.
- DUMP_ADDR  out  ADDR_W  source address of DUMP_DATA.
- DUMP_LAST  out  1  marks the final word.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal address and remaining counters 0.
- Reset assertion mid-dump aborts immediately, with no DONE pulse.
- IDLE:
  - START=1 captures BASE_ADDR and WORD_CNT and sets BUSY=1.
  - WORD_CNT=0 goes to FIN; otherwise goes to RD.
- RD: MEM_RD_EN=1 and MEM_RD_ADDR=cur_addr for exactly one cycle, then WAIT.
- WAIT: latch MEM_RD_DATA into the output register with DUMP_ADDR=cur_addr, then go to PRES.
- PRES:
  - DUMP_VALID=1; DUMP_DATA, DUMP_ADDR and DUMP_LAST stay stable until a handshake (VALID&READY).
  - On handshake: cur_addr += STRIDE (mod 2^ADDR_W, wraps silently) and remaining -= 1.
  - If remaining was 1, go to FIN; otherwise go to RD.
- DUMP_LAST=1 only while presenting the word where remaining==1.
- FIN: DONE=1 for one cycle, BUSY drops the same cycle, then IDLE.
- Latency: START to first DUMP_VALID is 3 cycles. With READY held high, throughput is 1 word per 3 cycles.
- DUMP_READY high before DUMP_VALID is legal. DUMP_VALID never drops without a handshake.
- START while BUSY is ignored; no restart, no queueing.
- No read is issued while a word is pending, so MEM_RD_DATA needs no buffering beyond the output register.

Optional Feature:
- Macro DATA_MEM_DUMP_CSUM_EN.
- When defined:
  - Adds output port DUMP_CSUM [DATA_W-1:0], a running mod-2^DATA_W sum of every handshaked word.
  - Cleared on accepted START and on reset.
  - Final value is valid from the DONE cycle and holds until the next START.
- When undefined: port and adder are absent; all other behaviour is identical.

Decomposition:
- Shared package dump_pkg holds:
  - state enum {IDLE, RD, WAIT, PRES, FIN};
  - default localparams for ADDR_W, DATA_W, STRIDE.
- No sub-module: the FSM, counters and output register fit in one module.
- The checksum is inline under the macro.

Test Plan:
- BASE_ADDR=0, WORD_CNT=3, memory [0]=0xDEADBEEF, [4]=0x12345678, [8]=0x00000001, READY=1 -> words at addresses 0, 4, 8 in order; DUMP_LAST only on the address-8 word; DONE 1 cycle after the third handshake; first VALID 3 cycles after START.
- Same setup, READY low for 5 cycles on the second word -> DATA/ADDR/LAST stable while stalled, no extra MEM_RD_EN, word accepted once.
- WORD_CNT=0 -> no MEM_RD_EN, no DUMP_VALID, DONE exactly 2 cycles after START.
- BASE_ADDR=0x3FC, WORD_CNT=2 -> addresses 0x3FC then 0x000 (wrap), both words correct.
- START re-pulsed during PRES, then RSTn low mid-dump -> second START ignored; on reset all outputs 0 immediately and no DONE; a fresh START after release dumps correctly.
- With DATA_MEM_DUMP_CSUM_EN: words 0xFFFFFFFF, 0x00000002 -> DUMP_CSUM=0x00000001 at DONE.
